// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline timing codes and MDU sequencing types for the decode-stage hazard logic.
package hazard_stall_ctrl_pkg;

    localparam int TIMING_W  = 2;
    localparam logic [TIMING_W-1:0] TUSE_NONE = 2'd3;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A source needs a stall when a pending writer will not have its result ready by the time D uses it.
    function automatic logic src_stall(
        input logic [4:0]          src,
        input logic [TIMING_W-1:0] tuse,
        input logic [4:0]          a3,
        input logic                we,
        input logic [TIMING_W-1:0] tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) && we && (a3 == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_seq.sv
// Multiply/divide unit sequencer: counts the E-stage busy window and emits a one-cycle done pulse.
//
// state   | meaning
// MD_IDLE | no MDU op in flight; a start loads the op latency
// MD_BUSY | op in flight; counter runs down to 1, then done pulses
module hazard_stall_ctrl_mdu_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_LAT,
    parameter int DIV_CYCLES  = DIV_LAT,
    parameter int CNT_W       = $clog2(DIV_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic E_md_start,
    input  logic E_md_is_div,
    output logic md_busy,
    output logic md_done
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            md_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (E_md_start) begin
                    cnt_nxt   = E_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                // A start arriving here is a protocol violation and is deliberately dropped.
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = MD_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign md_busy = (state == MD_BUSY);

    a_no_start_when_busy: assert property (
        @(posedge clk) disable iff (reset) !(E_md_start && state == MD_BUSY)
    );

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: stalls F/D and bubbles E on uncovered data or MDU hazards.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_LAT,
    parameter int DIV_CYCLES  = DIV_LAT,
    parameter int CNT_W       = $clog2(DIV_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_is_md,
    input  logic [4:0] E_a3,
    input  logic       E_we,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_a3,
    input  logic       M_we,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       stall,
    output logic       D_E_clr,
    output logic       md_busy,
    output logic       md_done
);

    logic stall_rs, stall_rt, stall_md;

    hazard_stall_ctrl_mdu_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_seq (
        .clk         (clk),
        .reset       (reset),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    assign stall_rs = src_stall(D_rs, D_tuse_rs, E_a3, E_we, E_tnew)
                    | src_stall(D_rs, D_tuse_rs, M_a3, M_we, M_tnew);
    assign stall_rt = src_stall(D_rt, D_tuse_rt, E_a3, E_we, E_tnew)
                    | src_stall(D_rt, D_tuse_rt, M_a3, M_we, M_tnew);

    // A start in E also blocks D so the next HI/LO op cannot slip past before busy rises.
    assign stall_md = D_is_md && (md_busy || E_md_start);

    assign stall   = stall_rs | stall_rt | stall_md;
    assign D_E_clr = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl: data hazards, MDU sequencing, async reset.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_a3, M_a3;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_we, M_we, E_md_start, E_md_is_div;
    logic       stall, D_E_clr, md_busy, md_done;

    int n_checks = 0;
    int n_errors = 0;

    hazard_stall_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_tuse_rs   (D_tuse_rs),
        .D_tuse_rt   (D_tuse_rt),
        .D_is_md     (D_is_md),
        .E_a3        (E_a3),
        .E_we        (E_we),
        .E_tnew      (E_tnew),
        .M_a3        (M_a3),
        .M_we        (M_we),
        .M_tnew      (M_tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .stall       (stall),
        .D_E_clr     (D_E_clr),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 1'b0;
        E_a3 = 5'd0; E_we = 1'b0; E_tnew = 2'd0;
        M_a3 = 5'd0; M_we = 1'b0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp});
        chk({tag, "_clr"}, {31'd0, D_E_clr}, {31'd0, exp});
    endtask

    // Issues a mult in the current cycle (cycle 0) and checks cycles 0..7.
    task automatic run_mult(input string tag);
        @(negedge clk);
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b0;
        #1;
        chk({tag, "_c0_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_c0_busy"}, {31'd0, md_busy}, 32'd0);
        @(negedge clk);
        E_md_start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            chk($sformatf("%s_c%0d_busy", tag, c), {31'd0, md_busy}, {31'd0, (c >= 1 && c <= 5)});
            chk($sformatf("%s_c%0d_done", tag, c), {31'd0, md_done}, {31'd0, (c == 6)});
            chk($sformatf("%s_c%0d_stall", tag, c), {31'd0, stall}, {31'd0, (c <= 5)});
            @(negedge clk);
        end
        D_is_md = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_done", {31'd0, md_done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use from E
        @(negedge clk);
        E_we = 1'b1; E_a3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
        chk_stall("loaduse", 1'b1);
        E_tnew = 2'd1;
        chk_stall("loaduse_ready", 1'b0);
        E_tnew = 2'd2; D_tuse_rs = 2'd0;
        chk_stall("loaduse_tuse0", 1'b1);

        // $0 and unused operand
        idle_inputs();
        E_we = 1'b1; E_a3 = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd0;
        chk_stall("reg0", 1'b0);
        idle_inputs();
        E_we = 1'b1; E_a3 = 5'd8; E_tnew = 2'd2; D_rt = 5'd8; D_tuse_rt = 2'd3;
        chk_stall("tuse_none", 1'b0);
        E_we = 1'b0; D_tuse_rt = 2'd0;
        chk_stall("no_we", 1'b0);

        // M-stage hazard
        idle_inputs();
        M_we = 1'b1; M_a3 = 5'd5; M_tnew = 2'd1; D_rt = 5'd5; D_tuse_rt = 2'd0;
        chk_stall("m_haz", 1'b1);
        D_tuse_rt = 2'd1;
        chk_stall("m_haz_ok", 1'b0);
        D_rt = 5'd6; D_tuse_rt = 2'd0;
        chk_stall("m_addr_diff", 1'b0);
        idle_inputs();

        run_mult("mult");

        // Back-to-back div
        @(negedge clk);
        E_md_start = 1'b1; E_md_is_div = 1'b1;
        @(negedge clk);
        E_md_start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            #1;
            chk($sformatf("div2_c%0d_busy", c), {31'd0, md_busy},
                {31'd0, ((c >= 1 && c <= 10) || (c >= 12 && c <= 21))});
            chk($sformatf("div2_c%0d_done", c), {31'd0, md_done}, {31'd0, (c == 11 || c == 22)});
            E_md_start = (c == 11);
            @(negedge clk);
        end
        E_md_start = 1'b0;

        // Async reset in cycle 4 of a div
        @(negedge clk);
        E_md_start = 1'b1; E_md_is_div = 1'b1;
        @(negedge clk);
        E_md_start = 1'b0; D_is_md = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("prerst_busy", {31'd0, md_busy}, 32'd1);
        chk("prerst_stall", {31'd0, stall}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, md_busy}, 32'd0);
        chk("midrst_done", {31'd0, md_done}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("postrst_c%0d_done", c), {31'd0, md_done}, 32'd0);
            chk($sformatf("postrst_c%0d_busy", c), {31'd0, md_busy}, 32'd0);
            @(negedge clk);
        end
        D_is_md = 1'b0;

        run_mult("mult_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
